// File: rtl/i2c_seq_pkg.sv
// ----------------------------------------------------------------------------
// i2c_seq_pkg
// Shared types for the I2C command sequencer: engine opcodes, engine response
// codes, completion status reported to requesters, sequencer FSM states and
// the fixed field widths of a transaction descriptor.
// ----------------------------------------------------------------------------
package i2c_seq_pkg;

    localparam int BUS_W  = 4;
    localparam int ADDR_W = 7;

    typedef enum logic [2:0] {
        OP_SET_BUS  = 3'd0,
        OP_START    = 3'd1,
        OP_STOP     = 3'd2,
        OP_WRITE    = 3'd3,
        OP_READ_ACK = 3'd4,
        OP_READ_NAK = 3'd5
    } cmd_op_e;

    typedef enum logic [1:0] {
        RSP_DONE     = 2'd0,
        RSP_NAK      = 2'd1,
        RSP_ARB_LOST = 2'd2,
        RSP_ERR      = 2'd3
    } rsp_status_e;

    typedef enum logic [1:0] {
        CPL_OK       = 2'd0,
        CPL_NAK      = 2'd1,
        CPL_ARB_LOST = 2'd2,
        CPL_TIMEOUT  = 2'd3
    } cpl_status_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SET_BUS = 3'd1,
        ST_START   = 3'd2,
        ST_ADDR    = 3'd3,
        ST_XFER    = 3'd4,
        ST_STOP    = 3'd5,
        ST_DONE    = 3'd6
    } seq_state_e;

    // Address byte on the wire: 7-bit slave address followed by the R/W bit.
    function automatic logic [7:0] addr_byte(input logic [ADDR_W-1:0] addr, input logic rw);
        return {addr, rw};
    endfunction

    // The final byte of a read is NAKed so the slave releases the bus.
    function automatic cmd_op_e read_op(input logic last);
        return last ? OP_READ_NAK : OP_READ_ACK;
    endfunction

endpackage

// File: rtl/i2c_rr_arbiter.sv
// ----------------------------------------------------------------------------
// i2c_rr_arbiter
// Combinational round-robin pick: returns the first asserted request found
// searching upward from ptr_i, wrapping past NUM_REQ-1 back to 0.
// Ports:
//   req_i    - request vector
//   ptr_i    - index with highest priority this round
//   valid_o  - at least one request present
//   idx_o    - index of the chosen requester
// ----------------------------------------------------------------------------
module i2c_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   idx_o
);

    int               k_s;
    logic [IDX_W-1:0] w_k;

    // Scan from the pointer; the first hit wins and later hits are masked.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        k_s     = 0;
        w_k     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k_s = int'(ptr_i) + i;
            if (k_s >= NUM_REQ) begin
                k_s = k_s - NUM_REQ;
            end else begin
                k_s = k_s;
            end
            w_k = IDX_W'(k_s);
            if (!valid_o && req_i[w_k]) begin
                valid_o = 1'b1;
                idx_o   = w_k;
            end else begin
                valid_o = valid_o;
            end
        end
    end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// i2c_cmd_sequencer
// Arbitrates NUM_REQ requesters onto one I2CMB byte-command engine and expands
// each granted descriptor into SET_BUS, START, WRITE(addr), data bytes, STOP.
// One command is outstanding at a time; every command waits for a response.
//
// Ports:
//   clk_i / rst_n_i             clock, asynchronous active-low reset
//   req_*_i                     per-requester request level and descriptor
//   gnt_o                       one-hot grant, held until done
//   wr_valid_i/wr_data_i/wr_ready_o   write byte stream from granted requester
//   rd_valid_o/rd_data_o        read byte pulses to granted requester
//   done_o/status_o             completion pulse and OK/NAK/ARB_LOST/TIMEOUT
//   cmd_*                       command port to the engine (valid/ready)
//   rsp_*                       response port from the engine
//
// Build option: define I2C_SEQ_TIMEOUT_EN to add a response watchdog that
// ends the transaction with TIMEOUT after TO_CYCLES cycles in a WAIT phase.
// ----------------------------------------------------------------------------
module i2c_cmd_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int LEN_W     = 8,
    parameter int TO_CYCLES = 4096
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*BUS_W-1:0] req_bus_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ-1:0]       req_rw_i,
    input  logic [NUM_REQ*LEN_W-1:0] req_len_i,
    output logic [NUM_REQ-1:0]       gnt_o,
    input  logic                     wr_valid_i,
    input  logic [7:0]               wr_data_i,
    output logic                     wr_ready_o,
    output logic                     rd_valid_o,
    output logic [7:0]               rd_data_o,
    output logic                     done_o,
    output logic [1:0]               status_o,
    output logic                     cmd_valid_o,
    input  logic                     cmd_ready_i,
    output logic [2:0]               cmd_op_o,
    output logic [7:0]               cmd_data_o,
    input  logic                     rsp_valid_i,
    input  logic [1:0]               rsp_status_i,
    input  logic [7:0]               rsp_data_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Per-requester descriptor fields split out of the packed ports.
    logic [BUS_W-1:0]  w_bus  [NUM_REQ];
    logic [ADDR_W-1:0] w_addr [NUM_REQ];
    logic [LEN_W-1:0]  w_len  [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_desc
        assign w_bus[g]  = req_bus_i[g*BUS_W +: BUS_W];
        assign w_addr[g] = req_addr_i[g*ADDR_W +: ADDR_W];
        assign w_len[g]  = req_len_i[g*LEN_W +: LEN_W];
    end

    seq_state_e        r_state;
    logic              r_wait;
    logic [IDX_W-1:0]  r_ptr;
    logic [IDX_W-1:0]  r_idx;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rw;
    logic [LEN_W-1:0]  r_cnt;
    cpl_status_e       r_cpl;

    logic [NUM_REQ-1:0] r_gnt;
    logic               r_wr_ready;
    logic               r_rd_valid;
    logic [7:0]         r_rd_data;
    logic               r_done;
    cpl_status_e        r_status;
    logic               r_cmd_valid;
    cmd_op_e            r_cmd_op;
    logic [7:0]         r_cmd_data;

    logic              w_arb_valid;
    logic [IDX_W-1:0]  w_arb_idx;
    rsp_status_e       w_rsp;
    logic              w_cnt_zero;
    logic              w_cnt_one;
    logic              w_cnt_two;
    logic [IDX_W-1:0]  w_ptr_next;
    logic              w_timeout;

    i2c_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i   (req_i),
        .ptr_i   (r_ptr),
        .valid_o (w_arb_valid),
        .idx_o   (w_arb_idx)
    );

    assign w_rsp      = rsp_status_e'(rsp_status_i);
    assign w_cnt_zero = (r_cnt == '0);
    assign w_cnt_one  = (r_cnt == LEN_W'(1));
    assign w_cnt_two  = (r_cnt == LEN_W'(2));
    assign w_ptr_next = (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + IDX_W'(1);

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYCLES + 1);
    logic [TO_W-1:0] r_to_cnt;

    // Watchdog: counts cycles spent in a WAIT phase, restarts on any response.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_to_cnt <= '0;
        end else if (!r_wait || rsp_valid_i) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    assign w_timeout = r_wait && !rsp_valid_i && (r_to_cnt == TO_W'(TO_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // Sequencer FSM: arbitration, command issue/wait, response handling, outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= ST_IDLE;
            r_wait      <= 1'b0;
            r_ptr       <= '0;
            r_idx       <= '0;
            r_addr      <= '0;
            r_rw        <= 1'b0;
            r_cnt       <= '0;
            r_cpl       <= CPL_OK;
            r_gnt       <= '0;
            r_wr_ready  <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= 8'h00;
            r_done      <= 1'b0;
            r_status    <= CPL_OK;
            r_cmd_valid <= 1'b0;
            r_cmd_op    <= OP_SET_BUS;
            r_cmd_data  <= 8'h00;
        end else begin
            r_wr_ready <= 1'b0;
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_valid) begin
                        r_idx       <= w_arb_idx;
                        r_addr      <= w_addr[w_arb_idx];
                        r_rw        <= req_rw_i[w_arb_idx];
                        r_cnt       <= w_len[w_arb_idx];
                        r_cpl       <= CPL_OK;
                        r_gnt       <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_arb_idx;
                        r_wait      <= 1'b0;
                        r_state     <= ST_SET_BUS;
                        r_cmd_valid <= 1'b1;
                        r_cmd_op    <= OP_SET_BUS;
                        r_cmd_data  <= {4'b0000, w_bus[w_arb_idx]};
                    end
                end

                ST_SET_BUS, ST_START, ST_ADDR, ST_XFER, ST_STOP: begin
                    if (!r_wait) begin
                        if (r_cmd_valid) begin
                            if (cmd_ready_i) begin
                                r_cmd_valid <= 1'b0;
                                r_wait      <= 1'b1;
                            end
                        end else if (wr_valid_i) begin
                            // Write-data fetch: only reachable in XFER of a write.
                            r_wr_ready  <= 1'b1;
                            r_cmd_valid <= 1'b1;
                            r_cmd_op    <= OP_WRITE;
                            r_cmd_data  <= wr_data_i;
                        end
                    end else if (rsp_valid_i) begin
                        r_wait <= 1'b0;
                        if (w_rsp == RSP_ARB_LOST || w_rsp == RSP_ERR) begin
                            // Bus no longer ours: a STOP would be meaningless.
                            r_cpl   <= CPL_ARB_LOST;
                            r_state <= ST_DONE;
                        end else if (r_state == ST_STOP) begin
                            r_state <= ST_DONE;
                        end else if (w_rsp == RSP_NAK) begin
                            r_cpl       <= CPL_NAK;
                            r_state     <= ST_STOP;
                            r_cmd_valid <= 1'b1;
                            r_cmd_op    <= OP_STOP;
                            r_cmd_data  <= 8'h00;
                        end else begin
                            case (r_state)
                                ST_SET_BUS: begin
                                    r_state     <= ST_START;
                                    r_cmd_valid <= 1'b1;
                                    r_cmd_op    <= OP_START;
                                    r_cmd_data  <= 8'h00;
                                end
                                ST_START: begin
                                    r_state     <= ST_ADDR;
                                    r_cmd_valid <= 1'b1;
                                    r_cmd_op    <= OP_WRITE;
                                    r_cmd_data  <= addr_byte(r_addr, r_rw);
                                end
                                ST_ADDR: begin
                                    if (w_cnt_zero) begin
                                        // Address probe: no data phase.
                                        r_state     <= ST_STOP;
                                        r_cmd_valid <= 1'b1;
                                        r_cmd_op    <= OP_STOP;
                                        r_cmd_data  <= 8'h00;
                                    end else if (r_rw) begin
                                        r_state     <= ST_XFER;
                                        r_cmd_valid <= 1'b1;
                                        r_cmd_op    <= read_op(w_cnt_one);
                                        r_cmd_data  <= 8'h00;
                                    end else begin
                                        // Writes enter XFER idle and fetch a byte first.
                                        r_state <= ST_XFER;
                                    end
                                end
                                ST_XFER: begin
                                    r_cnt <= r_cnt - LEN_W'(1);
                                    if (r_rw) begin
                                        r_rd_valid <= 1'b1;
                                        r_rd_data  <= rsp_data_i;
                                    end
                                    if (w_cnt_one) begin
                                        r_state     <= ST_STOP;
                                        r_cmd_valid <= 1'b1;
                                        r_cmd_op    <= OP_STOP;
                                        r_cmd_data  <= 8'h00;
                                    end else if (r_rw) begin
                                        r_cmd_valid <= 1'b1;
                                        r_cmd_op    <= read_op(w_cnt_two);
                                        r_cmd_data  <= 8'h00;
                                    end
                                end
                                default: begin
                                    r_state <= ST_DONE;
                                end
                            endcase
                        end
                    end else if (w_timeout) begin
                        r_wait  <= 1'b0;
                        r_cpl   <= CPL_TIMEOUT;
                        r_state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    r_done   <= 1'b1;
                    r_status <= r_cpl;
                    r_gnt    <= '0;
                    r_ptr    <= w_ptr_next;
                    r_state  <= ST_IDLE;
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_wait      <= 1'b0;
                    r_gnt       <= '0;
                    r_cmd_valid <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_o       = r_gnt;
    assign wr_ready_o  = r_wr_ready;
    assign rd_valid_o  = r_rd_valid;
    assign rd_data_o   = r_rd_data;
    assign done_o      = r_done;
    assign status_o    = r_status;
    assign cmd_valid_o = r_cmd_valid;
    assign cmd_op_o    = r_cmd_op;
    assign cmd_data_o  = r_cmd_data;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// tb_i2c_cmd_sequencer
// Directed bench: a behavioural engine answers each accepted command one cycle
// after the handshake, following a per-command response script, and logs the
// command stream. Expected command streams and statuses are hand-computed.
// ----------------------------------------------------------------------------
module tb_i2c_cmd_sequencer;
    import i2c_seq_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int LEN_W   = 8;

    logic                      clk_s = 1'b0;
    logic                      rst_n_s;
    logic [NUM_REQ-1:0]        req_s;
    logic [NUM_REQ*4-1:0]      req_bus_s;
    logic [NUM_REQ*7-1:0]      req_addr_s;
    logic [NUM_REQ-1:0]        req_rw_s;
    logic [NUM_REQ*LEN_W-1:0]  req_len_s;
    logic [NUM_REQ-1:0]        gnt_s;
    logic                      wr_valid_s;
    logic [7:0]                wr_data_s;
    logic                      wr_ready_s;
    logic                      rd_valid_s;
    logic [7:0]                rd_data_s;
    logic                      done_s;
    logic [1:0]                status_s;
    logic                      cmd_valid_s;
    logic                      cmd_ready_s;
    logic [2:0]                cmd_op_s;
    logic [7:0]                cmd_data_s;
    logic                      rsp_valid_s;
    logic [1:0]                rsp_status_s;
    logic [7:0]                rsp_data_s;

    i2c_cmd_sequencer #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W), .TO_CYCLES(4096)) dut (
        .clk_i        (clk_s),
        .rst_n_i      (rst_n_s),
        .req_i        (req_s),
        .req_bus_i    (req_bus_s),
        .req_addr_i   (req_addr_s),
        .req_rw_i     (req_rw_s),
        .req_len_i    (req_len_s),
        .gnt_o        (gnt_s),
        .wr_valid_i   (wr_valid_s),
        .wr_data_i    (wr_data_s),
        .wr_ready_o   (wr_ready_s),
        .rd_valid_o   (rd_valid_s),
        .rd_data_o    (rd_data_s),
        .done_o       (done_s),
        .status_o     (status_s),
        .cmd_valid_o  (cmd_valid_s),
        .cmd_ready_i  (cmd_ready_s),
        .cmd_op_o     (cmd_op_s),
        .cmd_data_o   (cmd_data_s),
        .rsp_valid_i  (rsp_valid_s),
        .rsp_status_i (rsp_status_s),
        .rsp_data_i   (rsp_data_s)
    );

    always #5 clk_s = ~clk_s;

    int n_checks = 0;
    int n_fail   = 0;

    // Engine model state and observation logs.
    logic [2:0]  log_op[$];
    logic [7:0]  log_dat[$];
    logic [1:0]  rsp_script [0:31];
    logic [7:0]  rd_script[$];
    logic [7:0]  rd_seen[$];
    logic [7:0]  wbytes[$];
    logic [3:0]  gnt_hist[$];
    logic [3:0]  gnt_prev = 4'b0000;
    int          widx = 0;
    int          wr_ready_cnt = 0;
    int          rsp_hold_from = 1000;
    logic        pend = 1'b0;
    logic [1:0]  pend_st = 2'b00;
    logic [7:0]  pend_dat = 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] pk(input logic [2:0] op, input logic [7:0] dat);
        return {op, dat};
    endfunction

    // Command data is only meaningful for SET_BUS and WRITE.
    task automatic check_cmds(input string tag, input logic [10:0] exp[$]);
        logic [10:0] got;
        check_eq({tag, "_ncmd"}, log_op.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < log_op.size()) begin
                got = (exp[i][10:8] == 3'(OP_SET_BUS) || exp[i][10:8] == 3'(OP_WRITE))
                      ? {log_op[i], log_dat[i]} : {log_op[i], exp[i][7:0]};
            end else begin
                got = 11'h7FF;
            end
            check_eq($sformatf("%s_cmd%0d", tag, i), got, exp[i]);
        end
    endtask

    task automatic set_desc(input int r, input logic [3:0] bus, input logic [6:0] addr,
                            input logic rw, input logic [7:0] len);
        req_bus_s[r*4 +: 4]         = bus;
        req_addr_s[r*7 +: 7]        = addr;
        req_rw_s[r]                 = rw;
        req_len_s[r*LEN_W +: LEN_W] = len;
    endtask

    task automatic clear_logs();
        log_op.delete();
        log_dat.delete();
        rd_seen.delete();
        rd_script.delete();
        gnt_hist.delete();
        wbytes.delete();
        widx          = 0;
        wr_ready_cnt  = 0;
        rsp_hold_from = 1000;
        for (int i = 0; i < 32; i++) rsp_script[i] = 2'(RSP_DONE);
    endtask

    task automatic wait_done(input string tag, input int budget, output logic [1:0] st);
        bit seen;
        seen = 1'b0;
        st   = 2'b00;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk_s);
            if (done_s) begin
                seen = 1'b1;
                st   = status_s;
            end
        end
        check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    // Engine + monitor, evaluated on the falling edge.
    initial begin
        int idx;
        forever begin
            @(negedge clk_s);
            if (pend) begin
                rsp_valid_s  = 1'b1;
                rsp_status_s = pend_st;
                rsp_data_s   = pend_dat;
                pend         = 1'b0;
            end else begin
                rsp_valid_s  = 1'b0;
                rsp_status_s = 2'b00;
                rsp_data_s   = 8'h00;
            end
            if (rst_n_s && cmd_valid_s && cmd_ready_s) begin
                idx = log_op.size();
                log_op.push_back(cmd_op_s);
                log_dat.push_back(cmd_data_s);
                if (idx < rsp_hold_from) begin
                    pend     = 1'b1;
                    pend_st  = (idx < 32) ? rsp_script[idx] : 2'(RSP_DONE);
                    pend_dat = 8'h00;
                    if ((cmd_op_s == 3'(OP_READ_ACK) || cmd_op_s == 3'(OP_READ_NAK)) && rd_script.size() > 0)
                        pend_dat = rd_script.pop_front();
                end
            end
            if (wr_ready_s) begin
                wr_ready_cnt++;
                widx++;
            end
            wr_valid_s = (widx < wbytes.size());
            wr_data_s  = (widx < wbytes.size()) ? wbytes[widx] : 8'h00;
            if (rd_valid_s) rd_seen.push_back(rd_data_s);
            if (gnt_s != 4'b0000 && gnt_prev == 4'b0000) gnt_hist.push_back(gnt_s);
            gnt_prev = gnt_s;
        end
    end

    // Directed scenarios.
    initial begin
        logic [1:0]  st;
        logic [10:0] exp[$];
        int          stops;

        rst_n_s      = 1'b0;
        req_s        = '0;
        req_bus_s    = '0;
        req_addr_s   = '0;
        req_rw_s     = '0;
        req_len_s    = '0;
        cmd_ready_s  = 1'b1;
        wr_valid_s   = 1'b0;
        wr_data_s    = 8'h00;
        rsp_valid_s  = 1'b0;
        rsp_status_s = 2'b00;
        rsp_data_s   = 8'h00;
        clear_logs();

        // Reset state
        repeat (3) @(negedge clk_s);
        check_eq("rst_gnt", 32'(gnt_s), 32'd0);
        check_eq("rst_outs", {cmd_valid_s, done_s, wr_ready_s, rd_valid_s, status_s,
                              cmd_op_s, cmd_data_s, rd_data_s}, 32'd0);
        rst_n_s = 1'b1;
        repeat (2) @(negedge clk_s);

        // T1: req0 write, bus 2, addr 0x22, len 3
        clear_logs();
        set_desc(0, 4'd2, 7'h22, 1'b0, 8'd3);
        wbytes = '{8'hA1, 8'hA2, 8'hA3};
        req_s  = 4'b0001;
        wait_done("t1", 300, st);
        req_s = 4'b0000;
        check_eq("t1_status", 32'(st), 32'(CPL_OK));
        check_eq("t1_wr_ready", wr_ready_cnt, 32'd3);
        check_eq("t1_gnt", (gnt_hist.size() > 0) ? 32'(gnt_hist[0]) : 32'hFF, 32'h1);
        exp = '{pk(OP_SET_BUS, 8'h02), pk(OP_START, 8'h00), pk(OP_WRITE, 8'h44),
                pk(OP_WRITE, 8'hA1), pk(OP_WRITE, 8'hA2), pk(OP_WRITE, 8'hA3), pk(OP_STOP, 8'h00)};
        check_cmds("t1", exp);

        // T2: req1 read, addr 0x50, len 2
        clear_logs();
        set_desc(1, 4'd1, 7'h50, 1'b1, 8'd2);
        rd_script = '{8'h5A, 8'h3C};
        req_s = 4'b0010;
        wait_done("t2", 300, st);
        req_s = 4'b0000;
        check_eq("t2_status", 32'(st), 32'(CPL_OK));
        check_eq("t2_nrd", rd_seen.size(), 32'd2);
        check_eq("t2_rd0", (rd_seen.size() > 0) ? 32'(rd_seen[0]) : 32'hFFF, 32'h5A);
        check_eq("t2_rd1", (rd_seen.size() > 1) ? 32'(rd_seen[1]) : 32'hFFF, 32'h3C);
        exp = '{pk(OP_SET_BUS, 8'h01), pk(OP_START, 8'h00), pk(OP_WRITE, 8'hA1),
                pk(OP_READ_ACK, 8'h00), pk(OP_READ_NAK, 8'h00), pk(OP_STOP, 8'h00)};
        check_cmds("t2", exp);

        // T3: NAK on the address byte, req3 write len 4
        clear_logs();
        set_desc(3, 4'd3, 7'h33, 1'b0, 8'd4);
        wbytes = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
        rsp_script[2] = 2'(RSP_NAK);
        req_s = 4'b1000;
        wait_done("t3", 300, st);
        req_s = 4'b0000;
        check_eq("t3_status", 32'(st), 32'(CPL_NAK));
        check_eq("t3_wr_ready", wr_ready_cnt, 32'd0);
        exp = '{pk(OP_SET_BUS, 8'h03), pk(OP_START, 8'h00), pk(OP_WRITE, 8'h66), pk(OP_STOP, 8'h00)};
        check_cmds("t3", exp);

        // T4: all four requesting, address probes, five grants
        clear_logs();
        for (int r = 0; r < 4; r++) set_desc(r, 4'(r), 7'(8'h10 + r), 1'b0, 8'd0);
        req_s = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_done($sformatf("t4_%0d", k), 300, st);
            if (k == 4) req_s = 4'b0000;
            check_eq($sformatf("t4_status%0d", k), 32'(st), 32'(CPL_OK));
        end
        check_eq("t4_ngnt", gnt_hist.size(), 32'd5);
        exp = '{11'h1, 11'h2, 11'h4, 11'h8, 11'h1};
        for (int k = 0; k < 5; k++)
            check_eq($sformatf("t4_gnt%0d", k), (k < gnt_hist.size()) ? 32'(gnt_hist[k]) : 32'hFF, 32'(exp[k]));
        check_eq("t4_ncmd", log_op.size(), 32'd20);
        check_eq("t4_probe_addr", (log_op.size() > 2) ? {log_op[2], log_dat[2]} : 32'hFFFF, 32'(pk(OP_WRITE, 8'h20)));
        check_eq("t4_probe_stop", (log_op.size() > 3) ? 32'(log_op[3]) : 32'hF, 32'(OP_STOP));

        // T5: ARB_LOST on the second WRITE of req1, then req2 is served
        clear_logs();
        set_desc(1, 4'd5, 7'h2A, 1'b0, 8'd3);
        set_desc(2, 4'd6, 7'h11, 1'b0, 8'd0);
        wbytes = '{8'hC1, 8'hC2, 8'hC3};
        rsp_script[3] = 2'(RSP_ARB_LOST);
        req_s = 4'b0110;
        wait_done("t5a", 300, st);
        req_s = 4'b0100;
        check_eq("t5_status", 32'(st), 32'(CPL_ARB_LOST));
        check_eq("t5_wr_ready", wr_ready_cnt, 32'd1);
        check_eq("t5_ncmd", log_op.size(), 32'd4);
        stops = 0;
        foreach (log_op[i]) if (log_op[i] == 3'(OP_STOP)) stops++;
        check_eq("t5_nstop", stops, 32'd0);
        wait_done("t5b", 300, st);
        req_s = 4'b0000;
        check_eq("t5b_status", 32'(st), 32'(CPL_OK));
        check_eq("t5_gnt0", (gnt_hist.size() > 0) ? 32'(gnt_hist[0]) : 32'hFF, 32'h2);
        check_eq("t5_gnt1", (gnt_hist.size() > 1) ? 32'(gnt_hist[1]) : 32'hFF, 32'h4);
        check_eq("t5b_setbus", (log_op.size() > 4) ? {log_op[4], log_dat[4]} : 32'hFFFF, 32'(pk(OP_SET_BUS, 8'h06)));

        // T6: asynchronous reset while waiting on the first data WRITE
        clear_logs();
        set_desc(0, 4'd1, 7'h40, 1'b0, 8'd2);
        wbytes = '{8'hD1, 8'hD2};
        rsp_hold_from = 3;
        req_s = 4'b0001;
        for (int n = 0; n < 300 && log_op.size() < 4; n++) @(negedge clk_s);
        repeat (3) @(negedge clk_s);
        check_eq("t6_pre_gnt", 32'(gnt_s), 32'h1);
        check_eq("t6_pre_ncmd", log_op.size(), 32'd4);
        #2 rst_n_s = 1'b0;
        #1;
        check_eq("t6_rst_gnt", 32'(gnt_s), 32'd0);
        check_eq("t6_rst_outs", {cmd_valid_s, done_s, wr_ready_s, rd_valid_s, status_s,
                                 cmd_op_s, cmd_data_s, rd_data_s}, 32'd0);
        req_s = 4'b0000;
        repeat (2) @(negedge clk_s);
        rst_n_s = 1'b1;
        clear_logs();
        for (int r = 0; r < 4; r++) set_desc(r, 4'(r + 8), 7'(8'h60 + r), 1'b0, 8'd0);
        repeat (2) @(negedge clk_s);
        check_eq("t6_idle", {gnt_s, cmd_valid_s, done_s}, 32'd0);
        req_s = 4'b1111;
        wait_done("t6", 300, st);
        req_s = 4'b0000;
        check_eq("t6_status", 32'(st), 32'(CPL_OK));
        check_eq("t6_gnt_ptr0", (gnt_hist.size() > 0) ? 32'(gnt_hist[0]) : 32'hFF, 32'h1);
        check_eq("t6_setbus", (log_op.size() > 0) ? {log_op[0], log_dat[0]} : 32'hFFFF, 32'(pk(OP_SET_BUS, 8'h08)));

`ifdef I2C_SEQ_TIMEOUT_EN
        // T7: no response at all -> TIMEOUT, no STOP
        repeat (2) @(negedge clk_s);
        clear_logs();
        rsp_hold_from = 0;
        req_s = 4'b0010;
        wait_done("t7", 4400, st);
        req_s = 4'b0000;
        check_eq("t7_status", 32'(st), 32'(CPL_TIMEOUT));
        check_eq("t7_ncmd", log_op.size(), 32'd1);
`endif

        repeat (3) @(negedge clk_s);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_cmd_sequencer.md
Name: i2c_cmd_sequencer

Overview:
- Arbitrates NUM_REQ requesters for one shared I2CMB byte-level command engine.
- Expands each granted transaction descriptor into the byte-command sequence SET_BUS, START, WRITE(addr), WRITE/READ×len, STOP.
- Waits for the engine response after every command and reports completion status to the granted requester.
- Sits between system masters and the I2CMB command/response port; the I2C agent observes the resulting bus traffic.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LEN_W, 8, width of the byte-count field.
- TO_CYCLES, 4096, response-watchdog limit (used only with the optional feature).

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- req_i  in  NUM_REQ  per-requester transaction request, level
- req_bus_i  in  NUM_REQ*4  per-requester I2C bus id
- req_addr_i  in  NUM_REQ*7  per-requester 7-bit slave address
- req_rw_i  in  NUM_REQ  1 = read, 0 = write
- req_len_i  in  NUM_REQ*LEN_W  per-requester data byte count
- gnt_o  out  NUM_REQ  one-hot grant, held until done
- wr_valid_i  in  1  write byte valid, from granted requester
- wr_data_i  in  8  write byte
- wr_ready_o  out  1  write byte accepted
- rd_valid_o  out  1  read byte valid, one-cycle pulse
- rd_data_o  out  8  read byte
- done_o  out  1  transaction complete, one-cycle pulse
- status_o  out  2  status, valid with done_o: OK / NAK / ARB_LOST / TIMEOUT
- cmd_valid_o  out  1  command to engine
- cmd_ready_i  in  1  engine accepts command
- cmd_op_o  out  3  opcode: SET_BUS, START, STOP, WRITE, READ_ACK, READ_NAK
- cmd_data_o  out  8  command data (bus id, address byte, or write byte)
- rsp_valid_i  in  1  engine response valid
- rsp_status_i  in  2  DONE / NAK / ARB_LOST / ERR
- rsp_data_i  in  8  read byte

Behaviour:
- Reset values:
  - all outputs 0; status_o = OK; state = IDLE.
  - Round-robin pointer = 0.
  - Reset mid-transaction aborts immediately; no STOP is issued.
- Arbitration:
  - In IDLE, grant the first asserted req_i searching upward from the pointer, wrapping.
  - The pointer moves to grant+1 when done_o fires.
  - Descriptor fields are latched on grant; gnt_o asserts the cycle after the grant decision.
  - A requester dropping req_i while granted has no effect; the transaction completes.
- FSM states: IDLE → SET_BUS → START → ADDR → XFER → STOP → DONE → IDLE.
  - Each command state has an ISSUE phase and a WAIT phase.
  - ISSUE: cmd_valid_o is held until cmd_ready_i; op and data are stable while valid.
  - WAIT: wait for rsp_valid_i. At most one command is outstanding.
- Command contents:
  - SET_BUS: cmd_data_o = {4'b0, bus}.
  - ADDR: WRITE with cmd_data_o = {addr, rw}.
- XFER, write transaction:
  - wr_ready_o pulses for one cycle when a write byte is accepted with wr_valid_i, once per byte.
  - The accepted byte is issued as WRITE.
- XFER, read transaction:
  - Bytes 1..len-1 use READ_ACK; the last byte uses READ_NAK.
  - Each DONE response pulses rd_valid_o with rd_data_o = rsp_data_i.
- Byte counter: LEN_W wide, counts down. len = 0 skips XFER (address probe).
- Response handling:
  - NAK on ADDR or a WRITE: go to STOP, final status NAK; remaining bytes are not requested.
  - ARB_LOST in any state: skip STOP, go to DONE with status ARB_LOST.
  - ERR: treated as ARB_LOST.
  - rsp_valid_i arriving outside a WAIT phase is ignored.
- DONE state:
  - Pulses done_o with status_o, clears gnt_o, returns to IDLE.
  - A new grant can start the next cycle.
- Latency, zero-wait engine: one cycle per ISSUE plus one per WAIT per command.

Optional Feature:
- Macro: I2C_SEQ_TIMEOUT_EN.
- Enabled:
  - A counter runs in each WAIT phase and clears on rsp_valid_i.
  - On reaching TO_CYCLES: go to DONE with status TIMEOUT, no STOP issued.
- Disabled: no counter; WAIT phases wait indefinitely; TIMEOUT is never reported.

Decomposition:
- Shared package i2c_seq_pkg:
  - cmd-opcode enum, response-status enum, completion-status enum, FSM state enum.
  - Widths: bus id 4, address 7.
- Sub-module i2c_rr_arbiter: combinational round-robin grant from req and pointer.
- The FSM and counters stay in the top level.

Test Plan:
- Req0 write, bus 2, addr 0x22, len 3, bytes 0xA1/0xA2/0xA3, all DONE → commands SET_BUS(0x02), START, WRITE(0x44), WRITE(0xA1..0xA3), STOP; done_o with status OK; exactly 3 wr_ready_o pulses.
- Req1 read, addr 0x50, len 2, engine returns 0x5A, 0x3C → ops READ_ACK then READ_NAK; rd_valid_o pulses carrying 0x5A then 0x3C; status OK.
- NAK on ADDR for a write with len 4 → next command is STOP; zero wr_ready_o pulses; status NAK.
- req_i = 4'b1111 held for four transactions → grant order 0, 1, 2, 3; after the last, the pointer wraps to 0.
- ARB_LOST on the second WRITE → no STOP issued; status ARB_LOST; the next requester is granted afterwards.
- rst_n_i asserted low while in XFER WAIT → all outputs 0 asynchronously; after release, state IDLE and pointer 0. With I2C_SEQ_TIMEOUT_EN and no response for 4096 cycles → status TIMEOUT.
